// File: rtl/tpc_sram_bank_arbiter.sv
// tpc_sram_bank_arbiter: shares NBANK scratchpad banks among NREQ requesters.
// Each bank has its own round-robin arbiter, so different banks can grant in parallel.
// Read data comes back one cycle after the grant and is steered to the requester that was granted.
// The arbiter also counts the cycles in which at least one request was refused.
// Optional feature: define ARB_REQ0_PRIORITY_EN to give requester 0 absolute priority in its bank.
module tpc_sram_bank_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned NBANK      = 4,
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned BANK_DEPTH = 256
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NREQ-1:0]                       req,
    input  logic [NREQ-1:0]                       req_we,
    input  logic [NREQ*ADDR_W-1:0]                req_addr,
    input  logic [NREQ*DATA_W-1:0]                req_wdata,
    output logic [NREQ-1:0]                       gnt,
    output logic [NREQ-1:0]                       rsp_valid,
    output logic [NREQ*DATA_W-1:0]                rsp_rdata,
    output logic [NBANK-1:0]                      bank_en,
    output logic [NBANK-1:0]                      bank_we,
    output logic [NBANK*$clog2(BANK_DEPTH)-1:0]   bank_addr,
    output logic [NBANK*DATA_W-1:0]               bank_wdata,
    input  logic [NBANK*DATA_W-1:0]               bank_rdata,
    output logic [31:0]                           conflict_cnt
);

    localparam int unsigned BANK_W = $clog2(NBANK);
    localparam int unsigned BW     = $clog2(BANK_DEPTH);
    localparam int unsigned ID_W   = $clog2(NREQ);
    localparam int unsigned HI_W   = ADDR_W - BANK_W - BW;

`ifdef ARB_REQ0_PRIORITY_EN
    localparam bit REQ0_PRIO = 1'b1;
`else
    localparam bit REQ0_PRIO = 1'b0;
`endif

    logic [BANK_W-1:0] req_bank   [NREQ];
    logic [BW-1:0]     req_word   [NREQ];
    logic [DATA_W-1:0] req_wd     [NREQ];
    logic [ID_W-1:0]   rr_ptr     [NBANK];
    logic [ID_W-1:0]   win_id     [NBANK];
    logic [NBANK-1:0]  win_ok;
    logic [NBANK-1:0]  pend_valid;
    logic [ID_W-1:0]   pend_id    [NBANK];
    logic [DATA_W-1:0] rdata_q    [NREQ];
    logic [DATA_W-1:0] rsp_data   [NREQ];
    logic [NREQ-1:0]   unused_addr_hi;

    // Split each requester's address into bank select and word index; upper bits are ignored
    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign req_bank[i] = req_addr[i*ADDR_W +: BANK_W];
        assign req_word[i] = req_addr[i*ADDR_W + BANK_W +: BW];
        assign req_wd[i]   = req_wdata[i*DATA_W +: DATA_W];
        assign rsp_rdata[i*DATA_W +: DATA_W] = rsp_data[i];
        if (HI_W > 0) begin : g_hi
            assign unused_addr_hi[i] = ^req_addr[i*ADDR_W + BANK_W + BW +: HI_W];
        end else begin : g_nohi
            assign unused_addr_hi[i] = 1'b0;
        end
    end

    // Per-bank winner search starting at rr_ptr, then drive grants and the bank port
    always_comb begin
        win_ok     = '0;
        gnt        = '0;
        bank_en    = '0;
        bank_we    = '0;
        bank_addr  = '0;
        bank_wdata = '0;
        for (int b = 0; b < NBANK; b++) begin
            win_id[b] = '0;
            if (REQ0_PRIO && req[0] && req_bank[0] == BANK_W'(b)) begin
                win_ok[b] = 1'b1;
            end
            for (int k = 0; k < NREQ; k++) begin
                int unsigned     idx;
                logic [ID_W-1:0] sel;
                idx = 32'(rr_ptr[b]) + 32'(k);
                if (idx >= NREQ) begin
                    idx = idx - NREQ;
                end
                sel = ID_W'(idx);
                if (!win_ok[b] && req[sel] && req_bank[sel] == BANK_W'(b)) begin
                    win_ok[b] = 1'b1;
                    win_id[b] = sel;
                end
            end
            if (rst) begin
                win_ok[b] = 1'b0;
            end
            if (win_ok[b]) begin
                gnt[win_id[b]]                  = 1'b1;
                bank_en[b]                      = 1'b1;
                bank_we[b]                      = req_we[win_id[b]];
                bank_addr[b*BW +: BW]           = req_word[win_id[b]];
                bank_wdata[b*DATA_W +: DATA_W]  = req_wd[win_id[b]];
            end
        end
    end

    // Round-robin pointer advances past the granted requester (a priority grant to req 0 leaves it alone)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NBANK; b++) begin
                rr_ptr[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                if (win_ok[b] && !(REQ0_PRIO && win_id[b] == '0)) begin
                    rr_ptr[b] <= (win_id[b] == ID_W'(NREQ - 1)) ? '0 : win_id[b] + 1'b1;
                end
            end
        end
    end

    // Remember which requester owns each bank's read data arriving next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= '0;
            for (int b = 0; b < NBANK; b++) begin
                pend_id[b] <= '0;
            end
        end else begin
            pend_valid <= win_ok & ~bank_we;
            for (int b = 0; b < NBANK; b++) begin
                pend_id[b] <= win_id[b];
            end
        end
    end

    // Steer returning bank data to its requester; reset suppresses in-flight responses
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_data[i] = rdata_q[i];
        end
        for (int b = 0; b < NBANK; b++) begin
            if (pend_valid[b] && !rst) begin
                rsp_valid[pend_id[b]] = 1'b1;
                rsp_data[pend_id[b]]  = bank_rdata[b*DATA_W +: DATA_W];
            end
        end
    end

    // Hold the last delivered read word per requester until its next response
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid[i]) begin
                    rdata_q[i] <= rsp_data[i];
                end
            end
        end
    end

    // Saturating count of cycles with at least one refused request
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (|(req & ~gnt) && conflict_cnt != '1) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_tpc_sram_bank_arbiter.sv
// Directed bench for tpc_sram_bank_arbiter with a behavioural SRAM and a response scoreboard.
// Build with ARB_REQ0_PRIORITY_EN defined to exercise the requester-0 priority variant.
module tb_tpc_sram_bank_arbiter;

    typedef logic [255:0] word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [3:0]    req;
    logic [3:0]    req_we;
    logic [79:0]   req_addr;
    logic [1023:0] req_wdata;
    logic [3:0]    gnt;
    logic [3:0]    rsp_valid;
    logic [1023:0] rsp_rdata;
    logic [3:0]    bank_en;
    logic [3:0]    bank_we;
    logic [31:0]   bank_addr;
    logic [1023:0] bank_wdata;
    logic [1023:0] bank_rdata;
    logic [31:0]   conflict_cnt;

    word_t mem [4][256];
    word_t exp_q [4][$];
    int    vectors    = 0;
    int    miscompares = 0;

    localparam word_t D1 = 256'hDEAD_BEEF_0123_4567;

    tpc_sram_bank_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .bank_en      (bank_en),
        .bank_we      (bank_we),
        .bank_addr    (bank_addr),
        .bank_wdata   (bank_wdata),
        .bank_rdata   (bank_rdata),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic word_t pat(int b, int w);
        return {192'h0, 32'hC0DE_0000, 8'(b), 8'h00, 16'(w)};
    endfunction

    // Behavioural banks: preload on load, then one-cycle read latency
    always @(posedge clk) begin
        if (load) begin
            for (int b = 0; b < 4; b++) begin
                for (int w = 0; w < 256; w++) begin
                    mem[b][w] <= (b == 0 && w == 4) ? 256'hA5 : pat(b, w);
                end
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (bank_en[b]) begin
                    if (bank_we[b]) begin
                        mem[b][bank_addr[b*8 +: 8]] <= bank_wdata[b*256 +: 256];
                    end else begin
                        bank_rdata[b*256 +: 256] <= mem[b][bank_addr[b*8 +: 8]];
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input word_t act, input word_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every response must match the oldest expected word for that requester
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid[i] === 1'b1) begin
                if (exp_q[i].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rsp_unexpected[%0d]: got rsp_valid data %0h expected no response",
                             i, rsp_rdata[i*256 +: 256]);
                end else begin
                    word_t e;
                    e = exp_q[i].pop_front();
                    chk($sformatf("rsp_rdata[%0d]", i), rsp_rdata[i*256 +: 256], e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req    = '0;
        req_we = '0;
    endtask

    task automatic set_rd(input int i, input logic [19:0] a);
        req[i]             = 1'b1;
        req_we[i]          = 1'b0;
        req_addr[i*20 +: 20] = a;
    endtask

    task automatic set_wr(input int i, input logic [19:0] a, input word_t d);
        req[i]               = 1'b1;
        req_we[i]            = 1'b1;
        req_addr[i*20 +: 20]   = a;
        req_wdata[i*256 +: 256] = d;
    endtask

    task automatic expect_rd(input int i, input word_t d);
        exp_q[i].push_back(d);
    endtask

`ifndef ARB_REQ0_PRIORITY_EN
    localparam logic [3:0] T4_GNT [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    localparam int         T4_WIN [5] = '{0, 1, 2, 3, 0};
`endif

    initial begin
        rst       = 1'b1;
        load      = 1'b1;
        req_addr  = '0;
        req_wdata = '0;
        idle();
        tick();
        load = 1'b0;
        tick();
        // Requests during reset must not be granted
        req = 4'hF;
        #3;
        chk("gnt_in_reset", gnt, 0);
        chk("bank_en_in_reset", bank_en, 0);
        tick();
        idle();
        rst = 1'b0;
        #3;
        chk("reset_gnt", gnt, 0);
        chk("reset_bank_en", bank_en, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_conflict", conflict_cnt, 0);

        // Single read, bank0 word4
        tick();
        set_rd(0, 20'h10);
        expect_rd(0, 256'hA5);
        #3;
        chk("single_gnt", gnt, 4'b0001);
        chk("single_bank_en", bank_en, 4'b0001);
        tick();
        idle();
        #3;
        chk("single_conflict", conflict_cnt, 0);

        // Four requesters, four distinct banks
        tick();
        for (int i = 0; i < 4; i++) begin
            set_rd(i, 20'(i));
            expect_rd(i, pat(i, 0));
        end
        #3;
        chk("parallel_gnt", gnt, 4'b1111);
        tick();
        idle();
        #3;
        chk("parallel_conflict", conflict_cnt, 0);

        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;

`ifndef ARB_REQ0_PRIORITY_EN
        // All four contend for bank0: round-robin rotation
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                set_rd(i, 20'(i * 4));
            end
            expect_rd(T4_WIN[c], pat(0, T4_WIN[c]));
            #3;
            chk($sformatf("rr_gnt_c%0d", c), gnt, T4_GNT[c]);
            if (c == 4) begin
                chk("rr_conflict_4", conflict_cnt, 4);
            end
        end
        tick();
        idle();
        #3;
        chk("rr_conflict_5", conflict_cnt, 5);

        // Write and read collide on bank2: writer wins, reader retries
        tick();
        set_wr(1, 20'h22, D1);
        set_rd(3, 20'h26);
        #3;
        chk("wr_rd_gnt", gnt, 4'b0010);
        chk("wr_rd_bank_we", bank_we, 4'b0100);
        tick();
        req[1]    = 1'b0;
        req_we[1] = 1'b0;
        expect_rd(3, pat(2, 9));
        #3;
        chk("retry_gnt", gnt, 4'b1000);
        tick();
        idle();
        set_rd(0, 20'h22);
        expect_rd(0, D1);
        #3;
        chk("readback_gnt", gnt, 4'b0001);
        // Upper address bits are ignored: 0xFFC10 aliases bank0 word4
        tick();
        idle();
        set_rd(2, 20'hFFC10);
        expect_rd(2, 256'hA5);
        #3;
        chk("alias_gnt", gnt, 4'b0100);
        tick();
        idle();
        #3;
        chk("wr_rd_conflict", conflict_cnt, 6);
`else
        // Requester 0 beats requester 2 on bank1 while it keeps requesting
        for (int c = 0; c < 3; c++) begin
            tick();
            set_rd(0, 20'h01);
            set_rd(2, 20'h05);
            expect_rd(0, pat(1, 0));
            #3;
            chk($sformatf("prio_gnt_c%0d", c), gnt, 4'b0001);
        end
        tick();
        req[0] = 1'b0;
        expect_rd(2, pat(1, 1));
        #3;
        chk("prio_release_gnt", gnt, 4'b0100);
        tick();
        idle();
        #3;
        chk("prio_conflict", conflict_cnt, 3);
`endif

        // Read granted, then reset the next cycle: response must be dropped
        tick();
        set_rd(1, 20'h07);
        #3;
        chk("pre_reset_gnt", gnt, 4'b0010);
        tick();
        idle();
        rst = 1'b1;
        #3;
        chk("reset_drop_rsp", rsp_valid, 0);
        tick();
        rst = 1'b0;
        #3;
        chk("post_reset_rsp", rsp_valid, 0);
        chk("post_reset_conflict", conflict_cnt, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_rd(i, 20'(i * 4 + 3));
        end
        expect_rd(0, pat(3, 0));
        #3;
        chk("post_reset_gnt", gnt, 4'b0001);
        tick();
        idle();
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_q%0d", i), 256'(exp_q[i].size()), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
